// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the PC, issues sequential fetches to a
// 1-cycle synchronous instruction RAM, buffers returned words with their PC
// in a DEPTH-entry circular FIFO and presents the head on a valid/ready port.
// A taken branch flushes the FIFO, drops any in-flight response and redirects.
module ifetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic                         imem_req,
    input  logic [INSTR_W-1:0]           imem_rdata,
    input  logic                         br_taken,
    input  logic [ADDR_W-1:0]            br_target,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         ovf_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned CRD_W = OCC_W + 1;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic               r_ovf;
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];

    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_wr;
    logic               w_ovf_evt;
    logic [CRD_W-1:0]   w_credit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake, credit-based issue and FIFO write qualification.
    // Credit counts the in-flight response so a push can never find the FIFO full.
    always_comb begin
        w_pop     = (r_occ != '0) && out_ready && !br_taken;
        w_push    = r_inflight && !br_taken;
        w_full    = (r_occ == OCC_W'(DEPTH));
        w_wr      = w_push && (!w_full || w_pop);
        w_ovf_evt = w_push && w_full && !w_pop;
        w_credit  = {1'b0, r_occ} + CRD_W'(r_inflight) - CRD_W'(w_pop);
        imem_req  = !reset && !br_taken && (w_credit < CRD_W'(DEPTH));
    end

    // PC and in-flight tracking; a redirect replaces the PC and kills the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= imem_req;
            if (br_taken) begin
                r_fetch_pc <= br_target;
            end else if (imem_req) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + PC_STEP;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
            r_ovf    <= 1'b0;
        end else if (br_taken) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_occ <= r_occ + OCC_W'(w_wr) - OCC_W'(w_pop);
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // FIFO storage: returned word tagged with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (w_wr) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    assign imem_addr = r_fetch_pc;
    assign out_valid = (r_occ != '0);
    assign out_instr = r_mem_instr[r_rd_ptr];
    assign out_pc    = r_mem_pc[r_rd_ptr];
    assign occupancy = r_occ;
    assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: three instances (DEPTH 4, 1, 2), each with its own
// RAM model (RAM[i] = i, word addressed) and an expected-PC queue scoreboard.
// Directed scenarios run on the DEPTH=4 instance; all three then see random
// back-pressure/redirects/resets followed by a full-rate throughput window.
module tb_ifetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic        st_reset [3];
    logic        st_ready [3];
    logic        st_br    [3];
    logic [31:0] st_tgt   [3];
    logic        win;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D  = (g == 0) ? 4 : g;
        localparam int unsigned OW = $clog2(D + 1);

        logic [31:0]   imem_addr;
        logic [31:0]   imem_rdata;
        logic          imem_req;
        logic          out_valid;
        logic [31:0]   out_instr;
        logic [31:0]   out_pc;
        logic [OW-1:0] occupancy;
        logic          ovf_err;

        logic [31:0]   exp_q [$];
        logic [31:0]   exp_next = 32'h0;
        int unsigned   pops     = 0;
        int unsigned   win_cnt  = 0;

        ifetch_queue #(
            .ADDR_W   (32),
            .INSTR_W  (32),
            .DEPTH    (D),
            .RESET_PC (32'h0),
            .PC_STEP  (32'd4)
        ) u_dut (
            .clk        (clk),
            .reset      (st_reset[g]),
            .imem_addr  (imem_addr),
            .imem_req   (imem_req),
            .imem_rdata (imem_rdata),
            .br_taken   (st_br[g]),
            .br_target  (st_tgt[g]),
            .out_valid  (out_valid),
            .out_ready  (st_ready[g]),
            .out_instr  (out_instr),
            .out_pc     (out_pc),
            .occupancy  (occupancy),
            .ovf_err    (ovf_err)
        );

        // Synchronous-read instruction RAM, one cycle of latency.
        always @(posedge clk) imem_rdata <= ram_word(imem_addr);

        // Scoreboard: expected PCs restart at reset/redirect and are compared on each accept.
        always @(negedge clk) begin
            if (st_reset[g]) begin
                exp_q.delete();
                exp_next = 32'h0;
            end else if (st_br[g]) begin
                exp_q.delete();
                exp_next = st_tgt[g];
            end else if (out_valid && st_ready[g]) begin
                check($sformatf("d%0d_pc", D), out_pc, exp_q[0]);
                check($sformatf("d%0d_instr", D), out_instr, ram_word(exp_q[0]));
                void'(exp_q.pop_front());
                pops++;
                if (win) win_cnt++;
            end
            while (exp_q.size() < 8) begin
                exp_q.push_back(exp_next);
                exp_next = exp_next + 32'd4;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            st_reset[i] = 1'b1;
            st_ready[i] = 1'b1;
            st_br[i]    = 1'b0;
            st_tgt[i]   = 32'h0;
        end
        win = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // T1: reset release with consumer always ready
        st_reset[0] = 1'b0;
        @(negedge clk);
        check("rst_req",   g_dut[0].imem_req, 1);
        check("rst_addr",  g_dut[0].imem_addr, 32'h0);
        check("rst_occ",   g_dut[0].occupancy, 0);
        check("rst_valid", g_dut[0].out_valid, 0);
        check("rst_ovf",   g_dut[0].ovf_err, 0);
        check("rst_pc",    g_dut[0].out_pc, 32'h0);
        check("rst_instr", g_dut[0].out_instr, 32'h0);
        for (int k = 1; k < 8; k++) begin
            cyc();
            @(negedge clk);
            check("t1_valid", g_dut[0].out_valid, k >= 2);
            if (k >= 2) begin
                check("t1_pc",    g_dut[0].out_pc, 4 * (k - 2));
                check("t1_instr", g_dut[0].out_instr, k - 2);
            end
        end

        // T2: fresh start with consumer stalled for 10 cycles
        cyc(); st_reset[0] = 1'b1;
        cyc(); st_reset[0] = 1'b0; st_ready[0] = 1'b0;
        @(negedge clk);
        repeat (9) begin cyc(); @(negedge clk); end
        check("t2_occ",   g_dut[0].occupancy, 4);
        check("t2_req",   g_dut[0].imem_req, 0);
        check("t2_hold",  g_dut[0].imem_addr, 32'h10);
        check("t2_ovf",   g_dut[0].ovf_err, 0);
        check("t2_head",  g_dut[0].out_pc, 32'h0);
        cyc(); st_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            check("t2_valid", g_dut[0].out_valid, 1);
            check("t2_pc",    g_dut[0].out_pc, 4 * i);
        end

        // T3: single redirect in a steady stream
        cyc(); st_br[0] = 1'b1; st_tgt[0] = 32'h100;
        @(negedge clk);
        check("t3_noissue", g_dut[0].imem_req, 0);
        cyc(); st_br[0] = 1'b0;
        @(negedge clk);
        check("t3_v1",    g_dut[0].out_valid, 0);
        check("t3_req",   g_dut[0].imem_req, 1);
        check("t3_addr",  g_dut[0].imem_addr, 32'h100);
        cyc(); @(negedge clk);
        check("t3_v2",    g_dut[0].out_valid, 0);
        cyc(); @(negedge clk);
        check("t3_v3",    g_dut[0].out_valid, 1);
        check("t3_pc3",   g_dut[0].out_pc, 32'h100);
        cyc(); @(negedge clk);
        check("t3_pc4",   g_dut[0].out_pc, 32'h104);

        // T4: back-to-back redirects, last target wins
        cyc(); st_br[0] = 1'b1; st_tgt[0] = 32'h40;
        cyc(); st_tgt[0] = 32'h80;
        cyc(); st_br[0] = 1'b0;
        @(negedge clk);
        check("t4_addr",  g_dut[0].imem_addr, 32'h80);
        check("t4_req",   g_dut[0].imem_req, 1);
        cyc(); cyc(); @(negedge clk);
        check("t4_valid", g_dut[0].out_valid, 1);
        check("t4_pc",    g_dut[0].out_pc, 32'h80);

        // T5: reset with three entries buffered and a fetch in flight
        cyc(); st_ready[0] = 1'b0;
        cyc();
        cyc(); st_reset[0] = 1'b1;
        @(negedge clk);
        check("t5_pre_occ", g_dut[0].occupancy, 3);
        check("t5_pre_req", g_dut[0].imem_req, 0);
        cyc(); st_reset[0] = 1'b0; st_ready[0] = 1'b1;
        @(negedge clk);
        check("t5_occ",   g_dut[0].occupancy, 0);
        check("t5_valid", g_dut[0].out_valid, 0);
        check("t5_addr",  g_dut[0].imem_addr, 32'h0);
        check("t5_req",   g_dut[0].imem_req, 1);
        cyc(); cyc(); @(negedge clk);
        check("t5_pc",    g_dut[0].out_pc, 32'h0);

        // T6: random back-pressure, redirects (some near address wrap) and resets
        for (int n = 0; n < 800; n++) begin
            cyc();
            for (int i = 0; i < 3; i++) begin
                st_reset[i] = ($urandom_range(0, 99) == 0);
                st_ready[i] = ($urandom_range(0, 3) != 0);
                st_br[i]    = ($urandom_range(0, 11) == 0);
                st_tgt[i]   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                          : ($urandom & 32'h0000_FFFC);
            end
        end

        // Throughput window with consumer always ready
        cyc();
        for (int i = 0; i < 3; i++) begin
            st_reset[i] = 1'b0;
            st_ready[i] = 1'b1;
            st_br[i]    = 1'b0;
        end
        repeat (10) cyc();
        win = 1'b1;
        repeat (40) cyc();
        win = 1'b0;
        @(negedge clk);
        check("rate_d4", g_dut[0].win_cnt, 40);
        check("rate_d1", g_dut[1].win_cnt, 20);
        check("rate_d2", g_dut[2].win_cnt, 40);
        check("ovf_d4",  g_dut[0].ovf_err, 0);
        check("ovf_d1",  g_dut[1].ovf_err, 0);
        check("ovf_d2",  g_dut[2].ovf_err, 0);
        check("pops_d1", g_dut[1].pops >= 50, 1);
        check("pops_d2", g_dut[2].pops >= 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
